cache_set_ctrl: RTL and testbench

- Controller for one 4-way set-associative cache set with one data word per line.
- Accepts read/write requests from a single requester and performs the tag compare and hit/miss sequencing.
- Picks a victim using invalid-first, then least-recently-used; writes back dirty victims and refills from memory over a req/ack handshake.
- Sits between the core-side request port and the memory-side port; owns all tag, valid, dirty, data and age state for the set.

---
 rtl/cache_set_ctrl_pkg.sv | 21 ++
 rtl/lru_age4.sv | 52 +++++
 rtl/cache_set_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_cache_set_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_set_ctrl_pkg.sv
// Shared types and constants for the 4-way single-set cache controller.
// Holds the FSM encoding, way sizing and LRU age reset values.
package cache_set_ctrl_pkg;

   localparam int unsigned NUM_WAYS = 4;
   localparam int unsigned WAY_W    = 2;

   typedef logic [WAY_W-1:0] way_t;

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StLookup    = 3'd1,
      StWriteback = 3'd2,
      StRefill    = 3'd3,
      StRespond   = 3'd4
   } state_e;

   localparam way_t AGE_MAX = way_t'(NUM_WAYS - 1);
   localparam way_t AGE_RST [NUM_WAYS] = '{2'd0, 2'd1, 2'd2, 2'd3};

endpackage

// File: rtl/lru_age4.sv
// True-LRU age tracker for four ways: age 0 is most recent, age 3 is the eviction candidate.
// Ages stay a permutation of 0..3 and change only on a touch.
module lru_age4
   import cache_set_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_b,
   input  logic touch_en,
   input  way_t touch_way,
   output way_t oldest
);

   way_t age_q [NUM_WAYS];
   way_t age_d [NUM_WAYS];
   way_t touched_age;

   always_comb begin
      touched_age = age_q[touch_way];
      for (int i = 0; i < NUM_WAYS; i++) begin
         age_d[i] = age_q[i];
         if (touch_en) begin
            if (way_t'(i) == touch_way) begin
               age_d[i] = '0;
            end else if (age_q[i] < touched_age) begin
               age_d[i] = age_q[i] + 2'd1;
            end
         end
      end
   end

   always_comb begin
      oldest = '0;
      for (int i = 0; i < NUM_WAYS; i++) begin
         if (age_q[i] == AGE_MAX) begin
            oldest = way_t'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < NUM_WAYS; i++) begin
            age_q[i] <= AGE_RST[i];
         end
      end else begin
         for (int i = 0; i < NUM_WAYS; i++) begin
            age_q[i] <= age_d[i];
         end
      end
   end

endmodule

// File: rtl/cache_set_ctrl.sv
// Controller for one 4-way set: tag compare, invalid-first/LRU victim choice,
// dirty writeback and refill over a req/ack memory handshake.
module cache_set_ctrl
   import cache_set_ctrl_pkg::*;
#(
   parameter int unsigned TAG_W  = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [TAG_W-1:0]  req_tag,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic              rsp_hit,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [TAG_W-1:0]  mem_tag,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e state_q, state_d;

   logic              req_we_q;
   logic [TAG_W-1:0]  req_tag_q;
   logic [DATA_W-1:0] req_wdata_q;

   logic [TAG_W-1:0]    tag_q  [NUM_WAYS];
   logic [DATA_W-1:0]   data_q [NUM_WAYS];
   logic [NUM_WAYS-1:0] valid_q, dirty_q;
   way_t                victim_q;

   logic              rsp_hit_q;
   logic [DATA_W-1:0] rsp_rdata_q;

   logic              hit;
   way_t              hit_way, victim_sel, oldest;
   logic              cap_en, victim_en, clean_en, touch_en, rsp_en;
   logic              fill_en, fill_dirty;
   way_t              fill_way, touch_way;
   logic [DATA_W-1:0] fill_data;
   logic              rsp_hit_d;
   logic [DATA_W-1:0] rsp_rdata_d;

   lru_age4 u_lru (
      .clk       (clk),
      .rst_b     (rst_b),
      .touch_en  (touch_en),
      .touch_way (touch_way),
      .oldest    (oldest)
   );

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int i = 0; i < NUM_WAYS; i++) begin
         if (valid_q[i] && (tag_q[i] == req_tag_q)) begin
            hit     = 1'b1;
            hit_way = way_t'(i);
         end
      end
   end

   // Descending scan so the lowest-index invalid way wins.
   always_comb begin
      victim_sel = oldest;
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            victim_sel = way_t'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cap_en      = 1'b0;
      victim_en   = 1'b0;
      clean_en    = 1'b0;
      fill_en     = 1'b0;
      fill_way    = victim_q;
      fill_dirty  = 1'b0;
      fill_data   = req_wdata_q;
      touch_en    = 1'b0;
      touch_way   = victim_q;
      rsp_en      = 1'b0;
      rsp_hit_d   = 1'b0;
      rsp_rdata_d = req_wdata_q;

      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               cap_en  = 1'b1;
               state_d = StLookup;
            end
         end
         StLookup: begin
            if (hit) begin
               touch_en  = 1'b1;
               touch_way = hit_way;
               rsp_en    = 1'b1;
               rsp_hit_d = 1'b1;
               if (req_we_q) begin
                  fill_en    = 1'b1;
                  fill_way   = hit_way;
                  fill_dirty = 1'b1;
               end else begin
                  rsp_rdata_d = data_q[hit_way];
               end
               state_d = StRespond;
            end else begin
               victim_en = 1'b1;
               if (valid_q[victim_sel] && dirty_q[victim_sel]) begin
                  state_d = StWriteback;
               end else if (!req_we_q) begin
                  state_d = StRefill;
               end else begin
                  fill_en    = 1'b1;
                  fill_way   = victim_sel;
                  fill_dirty = 1'b1;
                  touch_en   = 1'b1;
                  touch_way  = victim_sel;
                  rsp_en     = 1'b1;
                  state_d    = StRespond;
               end
            end
         end
         StWriteback: begin
            if (mem_ack) begin
               if (!req_we_q) begin
                  clean_en = 1'b1;
                  state_d  = StRefill;
               end else begin
                  fill_en    = 1'b1;
                  fill_dirty = 1'b1;
                  touch_en   = 1'b1;
                  rsp_en     = 1'b1;
                  state_d    = StRespond;
               end
            end
         end
         StRefill: begin
            if (mem_ack) begin
               fill_en     = 1'b1;
               fill_data   = mem_rdata;
               touch_en    = 1'b1;
               rsp_en      = 1'b1;
               rsp_rdata_d = mem_rdata;
               state_d     = StRespond;
            end
         end
         StRespond: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready = (state_q == StIdle);
      rsp_valid = (state_q == StRespond);
      rsp_hit   = rsp_hit_q;
      rsp_rdata = rsp_rdata_q;
      mem_req   = (state_q == StWriteback) || (state_q == StRefill);
      mem_we    = (state_q == StWriteback);
      mem_tag   = '0;
      mem_wdata = '0;
      if (state_q == StWriteback) begin
         mem_tag   = tag_q[victim_q];
         mem_wdata = data_q[victim_q];
      end else if (state_q == StRefill) begin
         mem_tag = req_tag_q;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= StIdle;
         req_we_q    <= 1'b0;
         req_tag_q   <= '0;
         req_wdata_q <= '0;
         victim_q    <= '0;
         rsp_hit_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (cap_en) begin
            req_we_q    <= req_we;
            req_tag_q   <= req_tag;
            req_wdata_q <= req_wdata;
         end
         if (victim_en) begin
            victim_q <= victim_sel;
         end
         if (rsp_en) begin
            rsp_hit_q   <= rsp_hit_d;
            rsp_rdata_q <= rsp_rdata_d;
         end
      end
   end

   // A fill in the same cycle as a clean (write miss after writeback) must win.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         valid_q <= '0;
         dirty_q <= '0;
         for (int i = 0; i < NUM_WAYS; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (clean_en) begin
            dirty_q[victim_q] <= 1'b0;
         end
         if (fill_en) begin
            tag_q[fill_way]   <= req_tag_q;
            data_q[fill_way]  <= fill_data;
            valid_q[fill_way] <= 1'b1;
            dirty_q[fill_way] <= fill_dirty;
         end
      end
   end

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Directed, table-driven bench for cache_set_ctrl with a scripted memory responder
// and hand-written sequences for reset during refill.
module tb_cache_set_ctrl;

   logic       clk = 1'b0;
   logic       rst_b;
   logic       req_valid, req_ready, req_we;
   logic [7:0] req_tag, req_wdata;
   logic       rsp_valid, rsp_hit;
   logic [7:0] rsp_rdata;
   logic       mem_req, mem_we, mem_ack;
   logic [7:0] mem_tag, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   cache_set_ctrl #(.TAG_W(8), .DATA_W(8)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_tag   (req_tag),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_hit   (rsp_hit),
      .rsp_rdata (rsp_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_tag   (mem_tag),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       we;
      logic [7:0] tag;
      logic [7:0] wdata;
      logic [7:0] ack_data;
      int         delay;
      logic       toggle;
      logic       exp_hit;
      logic [7:0] exp_rdata;
      logic       exp_wb;
      logic [7:0] wb_tag;
      logic [7:0] wb_data;
      logic       exp_rf;
      logic [7:0] rf_tag;
   } vec_t;

   vec_t tbl [28];

   function automatic vec_t mk(input logic we, input logic [7:0] tag, input logic [7:0] wdata,
                               input logic [7:0] ack_data, input int delay, input logic toggle,
                               input logic exp_hit, input logic [7:0] exp_rdata,
                               input logic exp_wb, input logic [7:0] wb_tag,
                               input logic [7:0] wb_data, input logic exp_rf,
                               input logic [7:0] rf_tag);
      vec_t v;
      v.we = we; v.tag = tag; v.wdata = wdata; v.ack_data = ack_data; v.delay = delay;
      v.toggle = toggle; v.exp_hit = exp_hit; v.exp_rdata = exp_rdata; v.exp_wb = exp_wb;
      v.wb_tag = wb_tag; v.wb_data = wb_data; v.exp_rf = exp_rf; v.rf_tag = rf_tag;
      return v;
   endfunction

   function automatic void chk(input string name, input int idx, input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
      end
   endfunction

   task automatic do_reset();
      rst_b     = 1'b0;
      req_valid = 1'b0;
      mem_ack   = 1'b0;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_vec(input int idx);
      vec_t       v;
      int         cyc, cnt, wb_n, rf_n, wb_c, rf_c;
      bit         in_txn, done, ready_bad, stable_bad;
      logic [7:0] t0, d0;
      logic       we0;
      v = tbl[idx];
      cnt = 0;
      while (!req_ready && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("ready_before_req", idx, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = v.we; req_tag = v.tag; req_wdata = v.wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      cyc = 0; cnt = 0; wb_n = 0; rf_n = 0; wb_c = 0; rf_c = 0;
      in_txn = 0; done = 0; ready_bad = 0; stable_bad = 0;
      t0 = '0; d0 = '0; we0 = 1'b0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         mem_ack = 1'b0;
         if (v.toggle) begin
            req_valid = cyc[0]; req_we = 1'b0; req_tag = 8'h99;
         end
         if (rsp_valid) begin
            done = 1;
            req_valid = 1'b0;
         end else if (mem_req) begin
            if (req_ready) ready_bad = 1;
            if (!in_txn) begin
               in_txn = 1; cnt = 0; t0 = mem_tag; d0 = mem_wdata; we0 = mem_we;
               if (mem_we) begin
                  wb_c = cyc;
                  chk("wb_tag", idx, 32'(mem_tag), 32'(v.wb_tag));
                  chk("wb_data", idx, 32'(mem_wdata), 32'(v.wb_data));
               end else begin
                  rf_c = cyc;
                  chk("rf_tag", idx, 32'(mem_tag), 32'(v.rf_tag));
               end
            end else if (mem_tag !== t0 || mem_wdata !== d0 || mem_we !== we0) begin
               stable_bad = 1;
            end
            if (cnt == v.delay) begin
               mem_ack = 1'b1; mem_rdata = v.ack_data; in_txn = 0;
               if (mem_we) wb_n++;
               else rf_n++;
            end else begin
               cnt++;
            end
         end
      end
      chk("response_seen", idx, 32'(done), 32'd1);
      chk("rsp_hit", idx, 32'(rsp_hit), 32'(v.exp_hit));
      chk("rsp_rdata", idx, 32'(rsp_rdata), 32'(v.exp_rdata));
      chk("writeback_count", idx, 32'(wb_n), 32'(v.exp_wb));
      chk("refill_count", idx, 32'(rf_n), 32'(v.exp_rf));
      chk("ready_low_during_mem", idx, 32'(ready_bad), 32'd0);
      chk("mem_stable", idx, 32'(stable_bad), 32'd0);
      if (v.exp_hit) chk("hit_latency", idx, 32'(cyc), 32'd2);
      if (v.exp_wb && v.exp_rf) chk("wb_before_refill", idx, 32'(wb_c < rf_c), 32'd1);
      @(negedge clk);
      chk("single_rsp", idx, 32'(rsp_valid), 32'd0);
      chk("ready_after_rsp", idx, 32'(req_ready), 32'd1);
   endtask

   initial begin
      int cnt;
      // Phase 1: fills, hit, LRU eviction of a clean line.
      tbl[0]  = mk(0, 8'h10, 8'h00, 8'hA5, 0, 0, 0, 8'hA5, 0, 8'h00, 8'h00, 1, 8'h10);
      tbl[1]  = mk(0, 8'h10, 8'h00, 8'h00, 0, 0, 1, 8'hA5, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[2]  = mk(0, 8'h11, 8'h00, 8'hB1, 1, 0, 0, 8'hB1, 0, 8'h00, 8'h00, 1, 8'h11);
      tbl[3]  = mk(0, 8'h12, 8'h00, 8'hC2, 0, 0, 0, 8'hC2, 0, 8'h00, 8'h00, 1, 8'h12);
      tbl[4]  = mk(0, 8'h13, 8'h00, 8'hD3, 2, 0, 0, 8'hD3, 0, 8'h00, 8'h00, 1, 8'h13);
      tbl[5]  = mk(0, 8'h10, 8'h00, 8'h00, 0, 0, 1, 8'hA5, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[6]  = mk(0, 8'h14, 8'h00, 8'hE4, 0, 0, 0, 8'hE4, 0, 8'h00, 8'h00, 1, 8'h14);
      tbl[7]  = mk(0, 8'h11, 8'h00, 8'hB1, 0, 0, 0, 8'hB1, 0, 8'h00, 8'h00, 1, 8'h11);
      // Phase 2: dirty writeback with delayed ack and ignored requests.
      tbl[8]  = mk(0, 8'h10, 8'h00, 8'hA5, 0, 0, 0, 8'hA5, 0, 8'h00, 8'h00, 1, 8'h10);
      tbl[9]  = mk(0, 8'h11, 8'h00, 8'hB1, 0, 0, 0, 8'hB1, 0, 8'h00, 8'h00, 1, 8'h11);
      tbl[10] = mk(0, 8'h12, 8'h00, 8'hC2, 0, 0, 0, 8'hC2, 0, 8'h00, 8'h00, 1, 8'h12);
      tbl[11] = mk(0, 8'h13, 8'h00, 8'hD3, 0, 0, 0, 8'hD3, 0, 8'h00, 8'h00, 1, 8'h13);
      tbl[12] = mk(1, 8'h12, 8'h3C, 8'h00, 0, 0, 1, 8'h3C, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[13] = mk(0, 8'h10, 8'h00, 8'h00, 0, 0, 1, 8'hA5, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[14] = mk(0, 8'h11, 8'h00, 8'h00, 0, 0, 1, 8'hB1, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[15] = mk(0, 8'h13, 8'h00, 8'h00, 0, 0, 1, 8'hD3, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[16] = mk(0, 8'h20, 8'h00, 8'h4E, 5, 1, 0, 8'h4E, 1, 8'h12, 8'h3C, 1, 8'h20);
      tbl[17] = mk(0, 8'h12, 8'h00, 8'h3C, 0, 0, 0, 8'h3C, 0, 8'h00, 8'h00, 1, 8'h12);
      tbl[18] = mk(0, 8'h99, 8'h00, 8'h9A, 0, 0, 0, 8'h9A, 0, 8'h00, 8'h00, 1, 8'h99);
      tbl[19] = mk(1, 8'h20, 8'h66, 8'h00, 0, 0, 1, 8'h66, 0, 8'h00, 8'h00, 0, 8'h00);
      // Phase 3: write-miss allocation, then write miss over a dirty victim.
      tbl[20] = mk(1, 8'h55, 8'h77, 8'h00, 0, 0, 0, 8'h77, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[21] = mk(0, 8'h55, 8'h00, 8'h00, 0, 0, 1, 8'h77, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[22] = mk(0, 8'h30, 8'h00, 8'h5A, 0, 0, 0, 8'h5A, 0, 8'h00, 8'h00, 1, 8'h30);
      tbl[23] = mk(1, 8'h56, 8'h11, 8'h00, 0, 0, 0, 8'h11, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[24] = mk(1, 8'h57, 8'h22, 8'h00, 0, 0, 0, 8'h22, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[25] = mk(1, 8'h58, 8'h88, 8'h00, 1, 0, 0, 8'h88, 1, 8'h55, 8'h77, 0, 8'h00);
      tbl[26] = mk(0, 8'h58, 8'h00, 8'h00, 0, 0, 1, 8'h88, 0, 8'h00, 8'h00, 0, 8'h00);
      // After reset during refill, the previously valid line must miss.
      tbl[27] = mk(0, 8'h58, 8'h00, 8'h12, 0, 0, 0, 8'h12, 0, 8'h00, 8'h00, 1, 8'h58);

      rst_b = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_tag = '0; req_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      #3;
      chk("rst_req_ready", -1, 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", -1, 32'(rsp_valid), 32'd0);
      chk("rst_rsp_hit", -1, 32'(rsp_hit), 32'd0);
      chk("rst_rsp_rdata", -1, 32'(rsp_rdata), 32'd0);
      chk("rst_mem_req", -1, 32'(mem_req), 32'd0);
      chk("rst_mem_we", -1, 32'(mem_we), 32'd0);
      chk("rst_mem_tag", -1, 32'(mem_tag), 32'd0);
      chk("rst_mem_wdata", -1, 32'(mem_wdata), 32'd0);
      do_reset();

      for (int i = 0; i < 8; i++) run_vec(i);
      do_reset();
      for (int i = 8; i < 20; i++) run_vec(i);
      do_reset();
      for (int i = 20; i < 27; i++) run_vec(i);

      req_valid = 1'b1; req_we = 1'b0; req_tag = 8'h40;
      @(posedge clk);
      #1 req_valid = 1'b0;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!mem_req && cnt < 10);
      chk("midrst_in_refill", 100, 32'(mem_req && !mem_we), 32'd1);
      chk("midrst_rf_tag", 100, 32'(mem_tag), 32'h40);
      #2 rst_b = 1'b0;
      #1;
      chk("midrst_mem_req_drop", 100, 32'(mem_req), 32'd0);
      chk("midrst_ready", 100, 32'(req_ready), 32'd1);
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      chk("midrst_ready_after", 100, 32'(req_ready), 32'd1);
      run_vec(27);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
